// File: rtl/logic_pkg.sv
// ============================================================================
// Module      : logic_pkg
// Description : Shared encodings and widths for the logic arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_pkg;

    localparam int DATA_W = 8;

    localparam logic OP_AND = 1'b1;
    localparam logic OP_OR  = 1'b0;

    localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Grant counters stick at their maximum instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] value);
        logic [DATA_W-1:0] result;
        result = (value == CNT_MAX) ? value : value + 1'b1;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logical.sv
// ============================================================================
// Module      : logical
// Description : Combinational bitwise AND/OR unit selected by OP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logical
    import logic_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    output logic [WIDTH-1:0] Y
);

    assign Y = (OP == OP_AND) ? (A & B) : (A | B);

endmodule

`default_nettype wire

// File: rtl/logic_arbiter.sv
// ============================================================================
// Module      : logic_arbiter
// Description : Two-requester round-robin front end for one AND/OR unit,
//               one operation in flight, with saturating grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_arbiter
    import logic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              busy,
    output logic [DATA_W-1:0] gnt_cnt0,
    output logic [DATA_W-1:0] gnt_cnt1
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grant;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_op;
    logic              r_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_gnt_cnt0;
    logic [DATA_W-1:0] r_gnt_cnt1;
    logic [DATA_W-1:0] w_y;

    // Arbitration and next state; a tie goes to the requester not granted last.
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_gnt0 = r_last_grant;
                    w_gnt1 = ~r_last_grant;
                end else begin
                    w_gnt0 = req0_valid;
                    w_gnt1 = req1_valid;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_grant = w_gnt0 | w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= OP_OR;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_a          <= w_gnt1 ? req1_a  : req0_a;
            r_b          <= w_gnt1 ? req1_b  : req0_b;
            r_op         <= w_gnt1 ? req1_op : req0_op;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
        end
    end

    logical #(
        .WIDTH (DATA_W)
    ) u_logical (
        .A  (r_a),
        .B  (r_b),
        .OP (r_op),
        .Y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_data <= w_y;
            r_rsp_id   <= r_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            if (w_gnt0) begin
                r_gnt_cnt0 <= sat_inc(r_gnt_cnt0);
            end
            if (w_gnt1) begin
                r_gnt_cnt1 <= sat_inc(r_gnt_cnt1);
            end
        end
    end

    // Ready is qualified by rst_n so no requester is accepted while reset is held.
    assign req0_ready = w_gnt0 & rst_n;
    assign req1_ready = w_gnt1 & rst_n;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign busy       = (r_state != IDLE);
    assign gnt_cnt0   = r_gnt_cnt0;
    assign gnt_cnt1   = r_gnt_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_logic_arbiter.sv
// ============================================================================
// Module      : tb_logic_arbiter
// Description : Randomized self-checking bench for logic_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_op = 1'b0, req1_op = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic       busy;
    logic [7:0] gnt_cnt0, gnt_cnt1;

    always #5 clk = ~clk;

    logic_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one job at a time, result visible two cycles after grant.
    bit       m_busy;
    int       m_age;
    bit [7:0] m_data;
    bit       m_id;
    bit       m_last;
    int       m_cnt[2];

    // Stimulus knobs
    int       k_pct0, k_pct1, k_rr_pct;
    bit       k_fix0, k_fix1;
    bit [7:0] f_a0, f_b0, f_a1, f_b1;
    bit       f_op0, f_op1;
    bit       pend0, pend1;

    bit       q_gnt[$];
    bit [8:0] q_rsp[$];

    function automatic bit [7:0] ref_op(input bit [7:0] a, input bit [7:0] b, input bit op);
        return op ? (a & b) : (a | b);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_data = '0;
        m_id   = 1'b0;
        m_last = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic cycle();
        bit g0, g1;
        @(negedge clk);
        if (!pend0) begin
            if ($urandom_range(99) < k_pct0) begin
                pend0 = 1'b1;
                req0_valid = 1'b1;
                req0_a  = k_fix0 ? f_a0  : 8'($urandom);
                req0_b  = k_fix0 ? f_b0  : 8'($urandom);
                req0_op = k_fix0 ? f_op0 : 1'($urandom);
            end else begin
                req0_valid = 1'b0;
            end
        end
        if (!pend1) begin
            if ($urandom_range(99) < k_pct1) begin
                pend1 = 1'b1;
                req1_valid = 1'b1;
                req1_a  = k_fix1 ? f_a1  : 8'($urandom);
                req1_b  = k_fix1 ? f_b1  : 8'($urandom);
                req1_op = k_fix1 ? f_op1 : 1'($urandom);
            end else begin
                req1_valid = 1'b0;
            end
        end
        rsp_ready = ($urandom_range(99) < k_rr_pct);
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_busy) begin
            if (pend0 && pend1) begin
                g0 = ~m_last;
                g1 = m_last;
                // the requester that was not granted last wins the tie
                g0 = (m_last == 1'b1);
                g1 = (m_last == 1'b0);
            end else begin
                g0 = pend0;
                g1 = pend1;
            end
        end
        check("ready0", req0_ready, g0);
        check("ready1", req1_ready, g1);
        check("busy", busy, m_busy);
        check("rsp_valid", rsp_valid, m_busy && m_age >= 2);
        if (m_busy && m_age >= 2) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
        check("gnt_cnt0", gnt_cnt0, m_cnt[0]);
        check("gnt_cnt1", gnt_cnt1, m_cnt[1]);
        if (req0_ready) q_gnt.push_back(1'b0);
        else if (req1_ready) q_gnt.push_back(1'b1);
        if (rsp_valid && rsp_ready) q_rsp.push_back({rsp_id, rsp_data});
        if (g0 || g1) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_id   = g1;
            m_last = g1;
            m_data = g1 ? ref_op(req1_a, req1_b, req1_op) : ref_op(req0_a, req0_b, req0_op);
            if (m_cnt[g1] < 255) m_cnt[g1]++;
            if (g1) pend1 = 1'b0;
            else pend0 = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 2 && rsp_ready) m_busy = 1'b0;
            else m_age++;
        end
    endtask

    task automatic run_until_grants(input int n, input int budget);
        int start;
        int c;
        start = q_gnt.size();
        c = 0;
        while ((q_gnt.size() - start) < n && c < budget) begin
            cycle();
            c++;
        end
        check("grant_timeout", 32'((q_gnt.size() - start) >= n), 32'd1);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (m_busy && c < budget) begin
            cycle();
            c++;
        end
        check("drain_timeout", 32'(m_busy), 32'd0);
    endtask

    // Asserts reset asynchronously from the current time with both requesters valid.
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_cnt0", gnt_cnt0, 0);
        check("rst_cnt1", gnt_cnt1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        k_pct0 = 0; k_pct1 = 0; k_rr_pct = 100;
        k_fix0 = 1'b0; k_fix1 = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Single AND request from requester 0
        k_fix0 = 1'b1; f_a0 = 8'hF0; f_b0 = 8'h3C; f_op0 = 1'b1;
        k_pct0 = 100;
        q_rsp.delete();
        run_until_grants(1, 20);
        k_pct0 = 0;
        drain(20);
        check("and_count", q_rsp.size(), 1);
        if (q_rsp.size() > 0) begin
            check("and_data", q_rsp[0][7:0], 8'h30);
            check("and_id", q_rsp[0][8], 0);
        end

        // Single OR request from requester 1
        k_fix1 = 1'b1; f_a1 = 8'hA5; f_b1 = 8'h0F; f_op1 = 1'b0;
        k_pct1 = 100;
        q_rsp.delete();
        run_until_grants(1, 20);
        k_pct1 = 0;
        drain(20);
        check("or_count", q_rsp.size(), 1);
        if (q_rsp.size() > 0) begin
            check("or_data", q_rsp[0][7:0], 8'hAF);
            check("or_id", q_rsp[0][8], 1);
        end
        check("or_cnt1", gnt_cnt1, 1);
        k_fix0 = 1'b0; k_fix1 = 1'b0;

        // Contention: both always valid
        @(negedge clk); #2;
        do_reset();
        k_pct0 = 100; k_pct1 = 100; k_rr_pct = 100;
        q_gnt.delete();
        run_until_grants(4, 40);
        for (int i = 0; i < 4; i++) begin
            if (i < q_gnt.size()) check($sformatf("order%0d", i), q_gnt[i], i % 2);
        end
        cycle();
        check("cont_cnt0", gnt_cnt0, 2);
        check("cont_cnt1", gnt_cnt1, 2);

        // Backpressure: requester 1 keeps asking while the response is stalled
        @(negedge clk); #2;
        do_reset();
        k_pct0 = 100; k_pct1 = 0; k_rr_pct = 0;
        run_until_grants(1, 20);
        k_pct0 = 0; k_pct1 = 100;
        repeat (12) cycle();
        check("bp_held_valid", rsp_valid, 1);
        check("bp_held_ready1", req1_ready, 0);
        k_rr_pct = 100; k_pct1 = 0;
        cycle();
        cycle();
        check("bp_back_idle", busy, 0);
        drain(20);

        // Reset while executing
        @(negedge clk); #2;
        do_reset();
        k_pct0 = 100; k_pct1 = 0; k_rr_pct = 100;
        run_until_grants(1, 20);
        k_pct0 = 0;
        @(negedge clk); #2;
        check("mid_busy_pre", busy, 1);
        do_reset();
        k_pct0 = 100; k_pct1 = 100;
        q_gnt.delete();
        run_until_grants(1, 20);
        if (q_gnt.size() > 0) check("mid_first_tie", q_gnt[0], 0);

        // Saturation of requester 0's counter
        @(negedge clk); #2;
        do_reset();
        k_pct0 = 100; k_pct1 = 0; k_rr_pct = 100;
        run_until_grants(300, 1200);
        k_pct0 = 0;
        cycle();
        check("sat_cnt0", gnt_cnt0, 255);
        check("sat_cnt1", gnt_cnt1, 0);
        drain(20);

        // Random traffic
        @(negedge clk); #2;
        do_reset();
        k_pct0 = 60; k_pct1 = 60; k_rr_pct = 70;
        repeat (3000) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset. All logic SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-007 req0_op / req1_op  input  1 each  operation select: 1 = bitwise AND, 0 = bitwise OR.
REQ-008 rsp_valid  output  1  a result is presented.
REQ-009 rsp_ready  input  1  the consumer accepts the result.
REQ-010 rsp_data  output  8  the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 busy  output  1  the state machine is not in IDLE.
REQ-013 gnt_cnt0 / gnt_cnt1  output  8 each  count of grants per requester, saturating at 255.

Function
REQ-014 The state machine SHALL have three states: IDLE, EXEC and RESP.
REQ-015 In IDLE, with any reqN_valid high, the block SHALL assert exactly one reqN_ready in that same cycle (combinational from valid and the pointer), then:
- latch A, B, OP and the id;
- go to EXEC.
REQ-016 Arbitration SHALL be round-robin with a 1-bit last_grant pointer:
- if both requesters are valid, the requester not equal to last_grant wins;
- if only one is valid, it wins;
- last_grant SHALL update only on a grant.
REQ-017 In EXEC, the block SHALL compute the bitwise AND/OR of the latched operands, register the result into rsp_data, and go to RESP.
REQ-018 In RESP, rsp_valid SHALL be high and rsp_data/rsp_id SHALL be held stable.
REQ-019 On rsp_valid && rsp_ready the block SHALL return to IDLE.
REQ-020 Latency: a grant at cycle T SHALL give rsp_valid at cycle T+2.
REQ-021 Throughput: at most one operation SHALL be in flight; the next grant is possible at the cycle after the handshake (T+3 minimum).
REQ-022 reqN_ready SHALL be low in EXEC and RESP; requesters hold their valid and operands until ready.
REQ-023 rsp_ready held low SHALL stall the block in RESP indefinitely, with no loss or change of data.
REQ-024 gnt_cntN SHALL increment on each grant to requester N and SHALL stay at 255 once reached (no wrap-around).
REQ-025 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-026 While rst_n is low, the block SHALL immediately (asynchronously) force the following, including when reset occurs mid-operation (EXEC or RESP, in which case the in-flight result is discarded):
- state = IDLE;
- rsp_valid = 0, rsp_data = 0x00, rsp_id = 0;
- busy = 0, both reqN_ready = 0;
- last_grant = 1, so requester 0 wins the first tie;
- gnt_cnt0 = gnt_cnt1 = 0.
REQ-027 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Structure
REQ-028 A shared package logic_pkg SHALL hold:
- the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
- the op encoding constants (OP_AND=1, OP_OR=0);
- the data width parameter (8).
REQ-029 The computation SHALL be one sub-module: an instance of the team's 8-bit AND/OR unit "logical" (A, B, OP, Y), fed from the latched operand registers.
REQ-030 No other sub-modules SHALL be used; the arbiter, state machine and counters are in logic_arbiter.

Verification
REQ-031 Single request, AND:
- stimulus: req0 with A=0xF0, B=0x3C, op=1, granted at T;
- required: rsp_valid at T+2 with rsp_data=0x30 and rsp_id=0.
REQ-032 Single request, OR:
- stimulus: req1 with A=0xA5, B=0x0F, op=0;
- required: rsp_data=0xAF, rsp_id=1, gnt_cnt1=1.
REQ-033 Contention:
- stimulus: both requesters continuously valid for 4 operations after reset, rsp_ready=1;
- required: grant order 0,1,0,1 and gnt_cnt0=gnt_cnt1=2.
REQ-034 Backpressure:
- stimulus: rsp_ready=0 for 10 cycles during RESP;
- required: rsp_valid and rsp_data stable, both reqN_ready=0, then return to IDLE on the cycle rsp_ready is high.
REQ-035 Reset mid-operation:
- stimulus: rst_n asserted in EXEC;
- required: rsp_valid=0, busy=0 and counters=0 immediately; the next tie is granted to requester 0.
REQ-036 Saturation:
- stimulus: 300 grants to requester 0;
- required: gnt_cnt0=255 and gnt_cnt1=0.
